// File: rtl/pipe_pkg.sv
// Shared encodings for the MEM->WB pipeline slice: write-back select codes,
// the hard-wired zero register index and the elastic stage occupancy states.
package pipe_pkg;

  localparam int unsigned SEL_ALU  = 0;
  localparam int unsigned SEL_MEM  = 1;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry elastic register: a main slot driving the outputs plus a skid
// slot that absorbs one beat of back-pressure so in_ready_o comes straight from a flop.
module skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_fire, out_fire;
  stage_state_e     state;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = main_valid_q & out_ready_i;

  always_comb begin
    if (skid_valid_q) begin
      state = ST_FULL;
    end else if (main_valid_q) begin
      state = ST_ONE;
    end else begin
      state = ST_EMPTY;
    end
  end

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    // Flush only clears occupancy; payload may stay stale behind a cleared valid.
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d       = in_data_i;
            main_valid_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
          end else if (out_fire) begin
            main_valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Elastic MEM->WB pipeline stage: packs the write-back payload into a skid buffer and
// derives the valid-qualified RegWrite and the forwarding tap for the hazard unit.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_wen,
  output logic              fwd_wen,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int unsigned PayW = 2 * DATA_W + ADDR_W + SEL_W + 1;

  logic [PayW-1:0] pay_in, pay_out;
  logic            held_wen;

  assign pay_in = {in_alu, in_mem, in_waddr, in_sel, in_wen};

  skid_buf #(
    .WIDTH (PayW)
  ) u_skid_buf (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pay_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pay_out)
  );

  assign {out_alu, out_mem, out_waddr, out_sel, held_wen} = pay_out;

  // RegWrite must never leak from a stale or flushed payload.
  assign out_wen  = out_valid & held_wen;
  assign fwd_wen  = out_wen & (out_waddr != ADDR_W'(REG_ZERO));
  assign fwd_addr = out_waddr;
  assign fwd_data = (out_sel == SEL_W'(SEL_ALU)) ? out_alu : out_mem;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed bench for mem_wb_stage at default and wide parameters,
// checked against a queue-based model of the stage's occupancy and beat order.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] mem;
    logic [5:0]  waddr;
    logic [1:0]  sel;
    logic        wen;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  beat_t       in_b = '0;

  // narrow instance (defaults)
  logic        n_in_ready, n_out_valid, n_out_wen, n_fwd_wen;
  logic [31:0] n_out_alu, n_out_mem, n_fwd_data;
  logic [4:0]  n_out_waddr, n_fwd_addr;
  logic [1:0]  n_out_sel;
  // wide instance
  logic        w_in_ready, w_out_valid, w_out_wen, w_fwd_wen;
  logic [63:0] w_out_alu, w_out_mem, w_fwd_data;
  logic [5:0]  w_out_waddr, w_fwd_addr;
  logic [1:0]  w_out_sel;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  beat_t       q[$];

  always #5 clk = ~clk;

  mem_wb_stage u_dut_n (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (n_in_ready),
    .in_alu    (in_b.alu[31:0]),
    .in_mem    (in_b.mem[31:0]),
    .in_waddr  (in_b.waddr[4:0]),
    .in_sel    (in_b.sel),
    .in_wen    (in_b.wen),
    .out_valid (n_out_valid),
    .out_ready (out_ready),
    .out_alu   (n_out_alu),
    .out_mem   (n_out_mem),
    .out_waddr (n_out_waddr),
    .out_sel   (n_out_sel),
    .out_wen   (n_out_wen),
    .fwd_wen   (n_fwd_wen),
    .fwd_addr  (n_fwd_addr),
    .fwd_data  (n_fwd_data)
  );

  mem_wb_stage #(
    .DATA_W (64),
    .ADDR_W (6),
    .SEL_W  (2)
  ) u_dut_w (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_alu    (in_b.alu),
    .in_mem    (in_b.mem),
    .in_waddr  (in_b.waddr),
    .in_sel    (in_b.sel),
    .in_wen    (in_b.wen),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_alu   (w_out_alu),
    .out_mem   (w_out_mem),
    .out_waddr (w_out_waddr),
    .out_sel   (w_out_sel),
    .out_wen   (w_out_wen),
    .fwd_wen   (w_fwd_wen),
    .fwd_addr  (w_fwd_addr),
    .fwd_data  (w_fwd_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare both instances with what the model's queue says should be visible now.
  task automatic check_outputs();
    logic  vld;
    beat_t h;
    vld = (q.size() != 0);
    h   = vld ? q[0] : '0;
    check_eq("n_in_ready", 64'(n_in_ready), 64'(q.size() < 2));
    check_eq("w_in_ready", 64'(w_in_ready), 64'(q.size() < 2));
    check_eq("n_out_valid", 64'(n_out_valid), 64'(vld));
    check_eq("w_out_valid", 64'(w_out_valid), 64'(vld));
    check_eq("n_out_wen", 64'(n_out_wen), 64'(vld && h.wen));
    check_eq("w_out_wen", 64'(w_out_wen), 64'(vld && h.wen));
    check_eq("n_fwd_wen", 64'(n_fwd_wen), 64'(vld && h.wen && h.waddr[4:0] != 5'd0));
    check_eq("w_fwd_wen", 64'(w_fwd_wen), 64'(vld && h.wen && h.waddr != 6'd0));
    if (vld) begin
      check_eq("n_alu", 64'(n_out_alu), 64'(h.alu[31:0]));
      check_eq("w_alu", w_out_alu, h.alu);
      check_eq("n_mem", 64'(n_out_mem), 64'(h.mem[31:0]));
      check_eq("w_mem", w_out_mem, h.mem);
      check_eq("n_waddr", 64'(n_out_waddr), 64'(h.waddr[4:0]));
      check_eq("w_waddr", 64'(w_out_waddr), 64'(h.waddr));
      check_eq("n_sel", 64'(n_out_sel), 64'(h.sel));
      check_eq("w_sel", 64'(w_out_sel), 64'(h.sel));
      check_eq("n_fwd_addr", 64'(n_fwd_addr), 64'(h.waddr[4:0]));
      check_eq("w_fwd_addr", 64'(w_fwd_addr), 64'(h.waddr));
      check_eq("n_fwd_data", 64'(n_fwd_data),
               64'((h.sel == 2'd0) ? h.alu[31:0] : h.mem[31:0]));
      check_eq("w_fwd_data", w_fwd_data, (h.sel == 2'd0) ? h.alu : h.mem);
    end
  endtask

  task automatic check_all_zero();
    check_eq("rst_n_ready", 64'(n_in_ready), 64'd1);
    check_eq("rst_w_ready", 64'(w_in_ready), 64'd1);
    check_eq("rst_n_flags", 64'({n_out_valid, n_out_wen, n_fwd_wen}), 64'd0);
    check_eq("rst_w_flags", 64'({w_out_valid, w_out_wen, w_fwd_wen}), 64'd0);
    check_eq("rst_n_data", 64'(n_out_alu | n_out_mem | n_fwd_data), 64'd0);
    check_eq("rst_w_data", w_out_alu | w_out_mem | w_fwd_data, 64'd0);
    check_eq("rst_n_addr", 64'({n_out_waddr, n_out_sel, n_fwd_addr}), 64'd0);
    check_eq("rst_w_addr", 64'({w_out_waddr, w_out_sel, w_fwd_addr}), 64'd0);
  endtask

  // One clock: check at negedge, drive, then advance the model at the posedge.
  task automatic cycle(input logic v, input beat_t b, input logic ordy, input logic fl);
    logic pop, push;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      pop  = (q.size() != 0) && ordy;
      push = v && (q.size() < 2);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(b);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] alu, input logic [63:0] mem,
                               input logic [5:0] wa, input logic [1:0] sel, input logic wen);
    beat_t b;
    b.alu = alu; b.mem = mem; b.waddr = wa; b.sel = sel; b.wen = wen;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.alu   = {$urandom, $urandom};
    b.mem   = {$urandom, $urandom};
    b.waddr = 6'($urandom_range(0, 63));
    b.sel   = 2'($urandom_range(0, 3));
    b.wen   = 1'($urandom_range(0, 1));
    return b;
  endfunction

  initial begin
    reset = 1'b0;
    #12;
    check_all_zero();
    @(negedge clk);
    reset = 1'b1;

    // Streaming with out_ready held high; upper bits set to exercise the wide path.
    cycle(1'b1, mk(64'hF000_0000_0000_0011, 64'h1, 6'd1, 2'd0, 1'b1), 1'b1, 1'b0);
    cycle(1'b1, mk(64'hF000_0000_0000_0022, 64'h2, 6'd2, 2'd0, 1'b1), 1'b1, 1'b0);
    cycle(1'b1, mk(64'hF000_0000_0000_0033, 64'h3, 6'd3, 2'd0, 1'b1), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: A held, B in skid, C refused until the stage drains.
    cycle(1'b1, mk(64'hAAAA_0000_0000_000A, 64'h0, 6'd10, 2'd0, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(64'hBBBB_0000_0000_000B, 64'h0, 6'd11, 2'd0, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(64'hCCCC_0000_0000_000C, 64'h0, 6'd12, 2'd0, 1'b1), 1'b0, 1'b0);
    check_eq("bp_n_ready_low", 64'(n_in_ready), 64'd0);
    cycle(1'b1, mk(64'hCCCC_0000_0000_000C, 64'h0, 6'd12, 2'd0, 1'b1), 1'b1, 1'b0);
    cycle(1'b1, mk(64'hCCCC_0000_0000_000C, 64'h0, 6'd12, 2'd0, 1'b1), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush while FULL, offering 0x44 in the flush cycle.
    cycle(1'b1, mk(64'h1, 64'h0, 6'd1, 2'd0, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(64'h2, 64'h0, 6'd2, 2'd0, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(64'h44, 64'h0, 6'd4, 2'd0, 1'b1), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Forwarding tap: memory data selected, then the zero register suppresses fwd_wen.
    cycle(1'b1, mk(64'h5555, 64'hDEAD, 6'd5, 2'd1, 1'b1), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, mk(64'h5555, 64'hDEAD, 6'd0, 2'd1, 1'b1), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    cycle(1'b1, mk(64'h7, 64'h8, 6'd7, 2'd0, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(64'h9, 64'hA, 6'd9, 2'd1, 1'b1), 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero();
    q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), rnd_beat(), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 3));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
